// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache: 64 lines of 4 words, refilled one word per beat.
// A hit returns its word the next cycle. A miss stalls the fetcher with busy until the refill completes.
module icache #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int INDEX_BITS  = 6,
  parameter int OFFSET_BITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            rw_flag,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  busy,
  output logic                  done,
  input  logic                  flush,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_valid
);

  localparam int TAG_W = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS - 2;
  localparam int LINES = 1 << INDEX_BITS;
  localparam int WORDS = 1 << OFFSET_BITS;
  localparam int LINE_W = ADDR_WIDTH - OFFSET_BITS - 2;

  typedef enum logic [1:0] {IDLE, REFILL, RESP} state_t;

  state_t                  r_state, w_state_nxt;
  logic [LINES-1:0]        r_valid;
  logic [TAG_W-1:0]        r_tag  [LINES];
  logic [DATA_WIDTH-1:0]   r_data [LINES*WORDS];
  logic [ADDR_WIDTH-1:2]   r_addr;
  logic [OFFSET_BITS-1:0]  r_cnt;
  logic [DATA_WIDTH-1:0]   r_fill_word;
  logic                    r_flush_pend;
  logic                    r_busy, r_done, r_mem_req;
  logic [ADDR_WIDTH-1:0]   r_mem_addr;
  logic [DATA_WIDTH-1:0]   r_rdata;

  logic [OFFSET_BITS-1:0]  w_req_off, w_lat_off, w_cnt_inc;
  logic [INDEX_BITS-1:0]   w_req_idx, w_lat_idx;
  logic [TAG_W-1:0]        w_req_tag, w_lat_tag;
  logic [LINE_W-1:0]       w_lat_line;
  logic                    w_hit, w_beat, w_last;
  logic                    w_busy_nxt, w_done_nxt, w_mem_req_nxt, w_flush_pend_nxt;
  logic [ADDR_WIDTH-1:0]   w_mem_addr_nxt;
  logic [DATA_WIDTH-1:0]   w_rdata_nxt, w_fill_word_nxt;
  logic [OFFSET_BITS-1:0]  w_cnt_nxt;
  logic [ADDR_WIDTH-1:2]   w_addr_nxt;
  logic                    w_unused;

  assign w_unused   = ^{addr[1:0], rw_flag[1]};
  assign w_req_off  = addr[OFFSET_BITS+1:2];
  assign w_req_idx  = addr[INDEX_BITS+OFFSET_BITS+1:OFFSET_BITS+2];
  assign w_req_tag  = addr[ADDR_WIDTH-1:INDEX_BITS+OFFSET_BITS+2];
  assign w_lat_off  = r_addr[OFFSET_BITS+1:2];
  assign w_lat_idx  = r_addr[INDEX_BITS+OFFSET_BITS+1:OFFSET_BITS+2];
  assign w_lat_tag  = r_addr[ADDR_WIDTH-1:INDEX_BITS+OFFSET_BITS+2];
  assign w_lat_line = r_addr[ADDR_WIDTH-1:OFFSET_BITS+2];
  assign w_cnt_inc  = r_cnt + 1'b1;

  // A flush sampled together with a request wins, so that request is a miss.
  assign w_hit  = r_valid[w_req_idx] && (r_tag[w_req_idx] == w_req_tag) && !flush;
  assign w_beat = (r_state == REFILL) && mem_valid;
  assign w_last = w_beat && (&r_cnt);

  // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt      = r_state;
    w_busy_nxt       = r_busy;
    w_done_nxt       = 1'b0;
    w_mem_req_nxt    = r_mem_req;
    w_mem_addr_nxt   = r_mem_addr;
    w_rdata_nxt      = r_rdata;
    w_cnt_nxt        = r_cnt;
    w_fill_word_nxt  = r_fill_word;
    w_addr_nxt       = r_addr;
    w_flush_pend_nxt = r_flush_pend | flush;
    case (r_state)
      IDLE: begin
        if (rw_flag[0]) begin
          w_addr_nxt = addr[ADDR_WIDTH-1:2];
          if (w_hit) begin
            w_done_nxt  = 1'b1;
            w_rdata_nxt = r_data[{w_req_idx, w_req_off}];
          end else begin
            w_busy_nxt       = 1'b1;
            w_mem_req_nxt    = 1'b1;
            w_mem_addr_nxt   = {addr[ADDR_WIDTH-1:OFFSET_BITS+2], {(OFFSET_BITS+2){1'b0}}};
            w_cnt_nxt        = '0;
            // A flush here is applied before the fill starts, so it must not poison the new line.
            w_flush_pend_nxt = 1'b0;
            w_state_nxt      = REFILL;
          end
        end
      end
      REFILL: begin
        if (mem_valid) begin
          if (r_cnt == w_lat_off) w_fill_word_nxt = mem_rdata;
          w_cnt_nxt      = w_cnt_inc;
          w_mem_addr_nxt = {w_lat_line, w_cnt_inc, 2'b00};
          if (&r_cnt) begin
            w_busy_nxt    = 1'b0;
            w_mem_req_nxt = 1'b0;
            w_done_nxt    = 1'b1;
            w_rdata_nxt   = (r_cnt == w_lat_off) ? mem_rdata : r_fill_word;
            w_state_nxt   = RESP;
          end
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_valid      <= '0;
      r_addr       <= '0;
      r_cnt        <= '0;
      r_fill_word  <= '0;
      r_flush_pend <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= '0;
      r_rdata      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_addr       <= w_addr_nxt;
      r_cnt        <= w_cnt_nxt;
      r_fill_word  <= w_fill_word_nxt;
      r_flush_pend <= w_flush_pend_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_mem_req    <= w_mem_req_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_rdata      <= w_rdata_nxt;
      if (flush)
        r_valid <= '0;
      else if (w_last && !r_flush_pend)
        r_valid[w_lat_idx] <= 1'b1;
    end
  end

  // NOTE: data and tag arrays are not reset; the valid bits alone decide whether their contents count.
  always_ff @(posedge clk) begin
    if (w_beat) r_data[{w_lat_idx, r_cnt}] <= mem_rdata;
    if (w_last) r_tag[w_lat_idx] <= w_lat_tag;
  end

  assign read_data = r_rdata;
  assign busy      = r_busy;
  assign done      = r_done;
  assign mem_req   = r_mem_req;
  assign mem_addr  = r_mem_addr;

endmodule

// File: doc/icache.md
Name: icache

Overview:
- Read-only, direct-mapped instruction cache between the instruction fetcher and the memory/bus controller.
- Accepts one fetch at a time on the fetcher's rw_flag/addr interface and returns an instruction word with a one-cycle done pulse.
- On a miss it stalls the fetcher with busy and refills a full line from memory, one word per beat.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, instruction/memory word width
INDEX_BITS, 6, log2 of the number of lines (64 lines)
OFFSET_BITS, 2, log2 of words per line (4 words = 16 bytes); tag width = ADDR_WIDTH-INDEX_BITS-OFFSET_BITS-2

Ports:
clk  in  1  clock, rising-edge
rst  in  1  synchronous active-low reset (rst==0 resets on the clock edge)
rw_flag  in  2  from fetcher; bit0 = read request, bit1 = write (ignored), 00 = no request
addr  in  ADDR_WIDTH  fetch byte address; bits[1:0] ignored
read_data  out  DATA_WIDTH  instruction word, valid when done==1
busy  out  1  miss in progress; fetcher must hold rw_flag=00
done  out  1  one-cycle pulse: read_data valid for the accepted request
flush  in  1  invalidate all lines
mem_req  out  1  refill request, held high until the last beat is received
mem_addr  out  ADDR_WIDTH  word-aligned address of the beat being requested
mem_rdata  in  DATA_WIDTH  refill data
mem_valid  in  1  mem_rdata valid for the current mem_addr; may have gaps

Behaviour:
- Address split: offset = addr[OFFSET_BITS+1:2]; index = next INDEX_BITS bits; tag = remaining upper bits. Storage: data array, tag array, and a valid bit per line.
- Reset (rst==0 at an edge):
  - All valid bits cleared; state=IDLE.
  - busy=0, done=0, mem_req=0, mem_addr=0, read_data=0.
  - Reset mid-refill aborts the refill; the partial line stays invalid; later mem_valid pulses are ignored.
- FSM states: IDLE, REFILL, RESP.
- IDLE:
  - Request is accepted when rw_flag[0]==1 (rw_flag=11 behaves as a read). The address is latched.
  - Hit (valid and tag match): next cycle done=1, read_data=word, busy=0; state stays IDLE. Hit latency is 1 cycle.
  - Miss: next cycle busy=1, mem_req=1, mem_addr={tag,index,0,2'b00}, beat counter=0; go to REFILL.
  - rw_flag=00 or 10: no action. rw_flag[1] never modifies the cache.
- REFILL:
  - On each mem_valid: write mem_rdata to the line at the counter position, increment the counter, and set mem_addr to the next word.
  - Without mem_valid: hold all outputs.
  - When the counter reaches 2^OFFSET_BITS-1 and mem_valid is high: write the tag, set valid, drop mem_req next cycle, go to RESP.
  - Requests arriving while busy are ignored.
- RESP: one cycle with done=1, busy=0, read_data=requested word (taken from the fill, not a re-read); then return to IDLE.
- done is a pulse and deasserts the following cycle unless a new hit is accepted in that cycle. A back-to-back hit gives done on consecutive cycles.
- flush:
  - Clears all valid bits at the edge where it is sampled high.
  - Flush in IDLE with a simultaneous request: the request is treated as a miss.
  - Flush during REFILL: the refill completes and returns data, but the installed line stays invalid.
- Addresses wrap modulo 2^ADDR_WIDTH; no alignment error is raised.

Test Plan:
- Cold miss: read at 0x00000010; memory returns 0xA0,0xA1,0xA2,0xA3 with one idle gap before beat 2 -> busy=1, mem_addr sequence 0x10,0x14,0x18,0x1C held across the gap, mem_req low after the 4th beat, then a one-cycle done with read_data=0xA0.
- Hits: then read 0x14 and 0x1C on consecutive cycles -> done on two consecutive cycles with 0xA1 and 0xA3; mem_req stays 0.
- Conflict: read 0x410 (same index 1, tag 1), then 0x10 -> both miss, each refilling 4 beats; second returns 0xA0 again.
- Flush: flush=1 for one cycle, then read 0x10 -> miss and refill. Separately, flush during beat 2 of a refill -> done still returns data, and an immediate re-read of the same address misses.
- Reset mid-refill: rst=0 after 2 beats -> next cycle busy=0, mem_req=0, done=0; a stray mem_valid is ignored; read 0x10 after reset misses and refetches from 0x10.
- Ignored inputs: rw_flag=10 in IDLE -> no mem_req, no done; rw_flag=01 held during busy -> exactly one done per miss.
